tdm_mux4: RTL and testbench

TDM_MUX4 -- requirements
Module: tdm_mux4

---
 rtl/tdm_mux4.sv | 121 ++++++++++++
 tb/tb_tdm_mux4.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tdm_mux4.sv
// Four-lane time-division multiplexer: snapshots {D,C,B,A} at each frame start and
// serialises the snapshot onto data/sel, one lane per DIV-cycle slot.
module tdm_mux4 #(
  parameter int unsigned DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  output logic       data,
  output logic [1:0] sel,
  output logic       frame,
  output logic       active
);

  localparam int unsigned PW = (DIV < 1) ? 1 : $clog2(DIV + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        r_state;
  logic [3:0]    r_snap;
  logic [PW-1:0] r_pre;
  logic [1:0]    r_slot;
  logic          r_data;
  logic          r_frame;
  logic          r_active;

  state_t        w_state_nx;
  logic [3:0]    w_snap_nx;
  logic [PW-1:0] w_pre_nx;
  logic [1:0]    w_slot_nx;
  logic [1:0]    w_slot_inc;
  logic          w_data_nx;
  logic          w_frame_nx;
  logic          w_active_nx;

  assign w_slot_inc = r_slot + 2'd1;

  // NOTE: every next-state signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nx  = r_state;
    w_snap_nx   = r_snap;
    w_pre_nx    = r_pre;
    w_slot_nx   = r_slot;
    w_data_nx   = r_data;
    w_frame_nx  = 1'b0;
    w_active_nx = r_active;
    case (r_state)
      IDLE: begin
        w_pre_nx    = '0;
        w_slot_nx   = 2'd0;
        w_data_nx   = 1'b0;
        w_active_nx = 1'b0;
        if (en) begin
          w_state_nx  = RUN;
          w_snap_nx   = {D, C, B, A};
          w_data_nx   = A;
          w_frame_nx  = 1'b1;
          w_active_nx = 1'b1;
        end
      end
      RUN: begin
        if (r_pre == PRE_LAST) begin
          w_pre_nx = '0;
          if (r_slot != 2'd3) begin
            w_slot_nx = w_slot_inc;
            w_data_nx = r_snap[w_slot_inc];
          end else if (en) begin
            // Back-to-back frame: fresh snapshot, no idle gap.
            w_snap_nx  = {D, C, B, A};
            w_slot_nx  = 2'd0;
            w_data_nx  = A;
            w_frame_nx = 1'b1;
          end else begin
            w_state_nx  = IDLE;
            w_slot_nx   = 2'd0;
            w_data_nx   = 1'b0;
            w_active_nx = 1'b0;
          end
        end else begin
          w_pre_nx = r_pre + PW'(1);
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_snap   <= 4'd0;
      r_pre    <= '0;
      r_slot   <= 2'd0;
      r_data   <= 1'b0;
      r_frame  <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_snap   <= w_snap_nx;
      r_pre    <= w_pre_nx;
      r_slot   <= w_slot_nx;
      r_data   <= w_data_nx;
      r_frame  <= w_frame_nx;
      r_active <= w_active_nx;
    end
  end

  assign data   = r_data;
  assign sel    = r_slot;
  assign frame  = r_frame;
  assign active = r_active;

endmodule

// File: tb/tb_tdm_mux4.sv
// Bench for tdm_mux4: three instances (DIV=1,3,2) checked every cycle against a
// frame-position model, plus a DIV=1 loopback through a behavioural 1-to-4 demux.
module tb_tdm_mux4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] en;
  logic [3:0] lanes;  // {D,C,B,A}

  wire [2:0] o_data, o_frame, o_active;
  wire [1:0] o_sel0, o_sel1, o_sel2;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: per instance, whether a frame is running, cycle index within it, snapshot.
  bit       m_run  [3];
  int       m_k    [3];
  bit [3:0] m_snap [3];
  bit [3:0] snap_q [$];

  always #5 clk = ~clk;

  tdm_mux4 #(.DIV(1)) u_dut0 (.clk(clk), .rst(rst), .en(en[0]), .A(lanes[0]), .B(lanes[1]),
    .C(lanes[2]), .D(lanes[3]), .data(o_data[0]), .sel(o_sel0), .frame(o_frame[0]), .active(o_active[0]));
  tdm_mux4 #(.DIV(3)) u_dut1 (.clk(clk), .rst(rst), .en(en[1]), .A(lanes[0]), .B(lanes[1]),
    .C(lanes[2]), .D(lanes[3]), .data(o_data[1]), .sel(o_sel1), .frame(o_frame[1]), .active(o_active[1]));
  tdm_mux4 #(.DIV(2)) u_dut2 (.clk(clk), .rst(rst), .en(en[2]), .A(lanes[0]), .B(lanes[1]),
    .C(lanes[2]), .D(lanes[3]), .data(o_data[2]), .sel(o_sel2), .frame(o_frame[2]), .active(o_active[2]));

  function automatic int div_of(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] sel_of(input int i);
    case (i)
      0:       return o_sel0;
      1:       return o_sel1;
      default: return o_sel2;
    endcase
  endfunction

  task automatic check(input string tag, input int inst, input logic [1:0] obs, input logic [1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d: got %0d expected %0d", tag, inst, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int slot;
      slot = m_run[i] ? (m_k[i] / div_of(i)) : 0;
      check("active", i, {1'b0, o_active[i]}, {1'b0, m_run[i]});
      check("frame",  i, {1'b0, o_frame[i]},  {1'b0, m_run[i] && (m_k[i] == 0)});
      check("sel",    i, sel_of(i),           2'(slot));
      check("data",   i, {1'b0, o_data[i]},   {1'b0, m_run[i] && m_snap[i][slot]});
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_run[i]  = 1'b0;
      m_k[i]    = 0;
      m_snap[i] = 4'd0;
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!m_run[i]) begin
          if (en[i]) begin
            m_run[i] = 1'b1; m_k[i] = 0; m_snap[i] = lanes;
            if (i == 0) snap_q.push_back(lanes);
          end
        end else begin
          m_k[i]++;
          if (m_k[i] == 4 * div_of(i)) begin
            if (en[i]) begin
              m_k[i] = 0; m_snap[i] = lanes;
              if (i == 0) snap_q.push_back(lanes);
            end else begin
              m_run[i] = 1'b0; m_k[i] = 0;
            end
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drain_idle();
    int budget = 40;
    en = 3'b000;
    while ((m_run[0] || m_run[1] || m_run[2]) && budget > 0) begin
      tick();
      budget--;
    end
    n_assert++;
    assert (budget > 0) else begin
      n_fail++;
      $error("FAIL drain_timeout: got budget %0d expected >0", budget);
    end
  endtask

  initial begin
    logic [3:0] dmx;
    logic [3:0] exp_snap;
    int         frames;
    int         budget;

    rst = 1'b1; en = 3'b000; lanes = 4'b0000;
    model_reset();
    #1;
    check_all();

    // Edge with rst still high and en=1: nothing may start.
    en = 3'b111; lanes = 4'b1010;
    tick();
    rst = 1'b0;
    en  = 3'b001;

    // DIV=1, lanes 1010: (00,0),(01,1),(10,0),(11,1), frame again at cycle 4.
    repeat (6) tick();

    // Lanes change 0000->1111 at cycle 2 of a frame: rest of frame keeps 0s.
    budget = 10;
    while (m_k[0] != 3 && budget > 0) begin tick(); budget--; end
    lanes = 4'b0000;
    tick(); tick(); tick();
    lanes = 4'b1111;
    repeat (6) tick();
    drain_idle();

    // DIV=3, lanes 0110, en dropped at cycle 1: one frame, idle at cycle 12.
    lanes = 4'b0110;
    en = 3'b010;
    tick();
    en = 3'b000;
    repeat (12) tick();
    n_assert++;
    assert (o_active[1] === 1'b0 && o_sel1 === 2'b00 && o_data[1] === 1'b0) else begin
      n_fail++;
      $error("FAIL div3_end: got active=%b sel=%b data=%b expected 0/00/0", o_active[1], o_sel1, o_data[1]);
    end

    // DIV=2: asynchronous reset in the middle of slot 01.
    lanes = 4'b1111;
    en = 3'b100;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    tick();
    #2 rst = 1'b0;
    lanes = 4'b0101;
    tick();
    n_assert++;
    assert (o_frame[2] === 1'b1 && o_sel2 === 2'b00 && o_data[2] === 1'b1) else begin
      n_fail++;
      $error("FAIL restart: got frame=%b sel=%b data=%b expected 1/00/1", o_frame[2], o_sel2, o_data[2]);
    end
    drain_idle();

    // Loopback: DIV=1 into a 1-to-4 demux, random lanes every cycle, 100 frames.
    snap_q.delete();
    dmx    = 4'd0;
    frames = 0;
    budget = 1000;
    en     = 3'b001;
    while (frames < 100 && budget > 0) begin
      lanes = 4'($urandom);
      tick();
      budget--;
      if (o_active[0]) begin
        dmx[o_sel0] = o_data[0];
        if (o_sel0 == 2'd3) begin
          exp_snap = (snap_q.size() > 0) ? snap_q.pop_front() : 4'bxxxx;
          check("loopback", 0, dmx[1:0], exp_snap[1:0]);
          check("loopback", 0, dmx[3:2], exp_snap[3:2]);
          frames++;
        end
      end
    end
    n_assert++;
    assert (frames == 100) else begin
      n_fail++;
      $error("FAIL loopback_frames: got %0d expected 100", frames);
    end
    drain_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
